// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one single-port memory between fetch and MEM stages.
// Data wins arbitration; a starvation counter guarantees fetch progress.
module rv_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  input  logic        if_kill_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  output logic        if_stall_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  input  logic [7:0]  d_be_i,
  output logic [63:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        d_stall_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [63:0] m_addr_o,
  output logic [63:0] m_wdata_o,
  output logic [7:0]  m_be_o,
  input  logic        m_ready_i,
  input  logic        m_rvalid_i,
  input  logic [63:0] m_rdata_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t        r_state;
  logic          r_owner_d;
  logic [CW-1:0] r_starve_cnt;
  logic          r_killed;
  logic          r_sel_hi;
  logic          r_m_req;
  logic          r_m_we;
  logic [63:0]   r_m_addr;
  logic [63:0]   r_m_wdata;
  logic [7:0]    r_m_be;
  logic [63:0]   r_d_rdata;
  logic [31:0]   r_if_rdata;

  logic w_grant_d;
  logic w_grant_i;
  logic w_resp;
  logic w_kill_i;

  assign w_grant_d = d_req_i &&
                     (!if_req_i || (r_starve_cnt < SMAX));
  assign w_grant_i = !w_grant_d && if_req_i;
  assign w_resp    = (r_state == RESP);
  assign w_kill_i  = if_kill_i && !r_owner_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_owner_d    <= 1'b0;
      r_starve_cnt <= '0;
      r_killed     <= 1'b0;
      r_sel_hi     <= 1'b0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_be       <= '0;
      r_d_rdata    <= '0;
      r_if_rdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state   <= REQ;
            r_owner_d <= 1'b1;
            r_m_req   <= 1'b1;
            r_m_we    <= d_we_i;
            r_m_addr  <= d_addr_i;
            r_m_wdata <= d_wdata_i;
            r_m_be    <= d_be_i;
            if (if_req_i && (r_starve_cnt != SMAX))
              r_starve_cnt <= r_starve_cnt + CW'(1);
          end else if (w_grant_i) begin
            r_state      <= REQ;
            r_owner_d    <= 1'b0;
            r_m_req      <= 1'b1;
            r_m_we       <= 1'b0;
            r_m_addr     <= if_addr_i;
            r_m_wdata    <= '0;
            r_m_be       <= 8'hFF;
            r_sel_hi     <= if_addr_i[2];
            r_starve_cnt <= '0;
          end
        end
        REQ: begin
          if (w_kill_i)
            r_killed <= 1'b1;
          if (m_ready_i) begin
            r_m_req <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_kill_i)
            r_killed <= 1'b1;
          if (m_rvalid_i) begin
            r_state <= RESP;
            if (r_owner_d)
              r_d_rdata <= m_rdata_i;
            else
              r_if_rdata <= r_sel_hi ? m_rdata_i[63:32]
                                     : m_rdata_i[31:0];
          end
        end
        RESP: begin
          r_state  <= IDLE;
          r_killed <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A kill arriving in the RESP cycle itself still suppresses the pulse.
  assign d_valid_o  = w_resp && r_owner_d;
  assign if_valid_o = w_resp && !r_owner_d &&
                      !r_killed && !if_kill_i;

  assign if_stall_o = if_req_i && !if_valid_o;
  assign d_stall_o  = d_req_i && !d_valid_o;

  assign m_req_o    = r_m_req;
  assign m_we_o     = r_m_we;
  assign m_addr_o   = r_m_addr;
  assign m_wdata_o  = r_m_wdata;
  assign m_be_o     = r_m_be;
  assign d_rdata_o  = r_d_rdata;
  assign if_rdata_o = r_if_rdata;

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: vector table plus scoreboard for rv_mem_arb.
// Hand sequences cover contention, starvation and reset in WAIT.
module tb_rv_mem_arb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_req_i = 1'b0;
  logic [63:0] if_addr_i = '0;
  logic        if_kill_i = 1'b0;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        if_stall_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [63:0] d_addr_i = '0;
  logic [63:0] d_wdata_i = '0;
  logic [7:0]  d_be_i = '0;
  logic [63:0] d_rdata_o;
  logic        d_valid_o;
  logic        d_stall_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [63:0] m_addr_o;
  logic [63:0] m_wdata_o;
  logic [7:0]  m_be_o;
  logic        m_ready_i = 1'b0;
  logic        m_rvalid_i = 1'b0;
  logic [63:0] m_rdata_i = '0;

  always #5 clk = ~clk;

  rv_mem_arb #(.STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_kill_i(if_kill_i), .if_rdata_o(if_rdata_o),
    .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_rdata_o(d_rdata_o),
    .d_valid_o(d_valid_o), .d_stall_o(d_stall_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_ready_i(m_ready_i),
    .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          rdy;
    int          rv;
    logic [63:0] rdata;
    int          kill;
    bit          ev;
    logic [63:0] ed;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t sb[$];

  int          rdy_lat = 0;
  int          rv_lat = 0;
  int          rdy_cnt = 0;
  int          rv_cnt = 0;
  bit          acc = 1'b0;
  logic [63:0] rsp_data = '0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: ready after rdy_lat stalled cycles, response after rv_lat.
  always @(posedge clk) begin
    #1;
    m_ready_i  = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    if (acc) begin
      if (rv_cnt >= rv_lat) begin
        m_rvalid_i = 1'b1;
        m_rdata_i  = rsp_data;
        acc        = 1'b0;
      end else begin
        rv_cnt++;
      end
    end else if (m_req_o) begin
      if (rdy_cnt >= rdy_lat) begin
        m_ready_i = 1'b1;
        acc       = 1'b1;
        rdy_cnt   = 0;
        rv_cnt    = 0;
      end else begin
        rdy_cnt++;
      end
    end
  end

  function automatic vec_t mk(
    input bit is_d, input bit we,
    input logic [63:0] addr, input logic [63:0] wdata,
    input logic [7:0] be, input int rdy, input int rv,
    input logic [63:0] rdata, input int kill,
    input bit ev, input logic [63:0] ed, input int lat);
    vec_t t;
    t.is_d = is_d; t.we = we; t.addr = addr;
    t.wdata = wdata; t.be = be; t.rdy = rdy;
    t.rv = rv; t.rdata = rdata; t.kill = kill;
    t.ev = ev; t.ed = ed; t.lat = lat;
    return t;
  endfunction

  task automatic drop_all();
    d_req_i = 0; if_req_i = 0; if_kill_i = 0;
    d_we_i = 0; d_addr_i = '0; d_wdata_i = '0;
    d_be_i = '0; if_addr_i = '0;
  endtask

  task automatic run_vec(input vec_t t);
    vec_t e;
    bit got;
    bit vd;
    bit ov;
    rdy_lat = t.rdy; rv_lat = t.rv; rsp_data = t.rdata;
    if (t.ev) sb.push_back(t);
    got = 1'b0;
    tick();
    if (t.is_d) begin
      d_req_i = 1; d_we_i = t.we; d_addr_i = t.addr;
      d_wdata_i = t.wdata; d_be_i = t.be;
    end else begin
      if_req_i = 1; if_addr_i = t.addr;
    end
    if_kill_i = (t.kill == 0);
    for (int c = 0; c <= t.lat + 4; c++) begin
      if (c > 0) begin
        tick();
        if_kill_i = (t.kill == c);
      end
      @(negedge clk);
      vd = t.is_d ? d_valid_o : if_valid_o;
      ov = t.is_d ? if_valid_o : d_valid_o;
      chk("m_req_o", m_req_o, (c >= 1 && c <= 1 + t.rdy));
      if (m_req_o) begin
        chk("m_addr_o", m_addr_o, t.addr);
        chk("m_we_o", m_we_o, t.is_d ? t.we : 1'b0);
        chk("m_be_o", m_be_o, t.is_d ? t.be : 8'hFF);
        chk("m_wdata_o", m_wdata_o, t.is_d ? t.wdata : 64'h0);
      end
      chk("other_valid", ov, 0);
      chk(t.is_d ? "d_stall_o" : "if_stall_o",
          t.is_d ? d_stall_o : if_stall_o,
          !(t.ev && c == t.lat));
      if (vd) begin
        got = 1'b1;
        if (!t.ev) begin
          chk("killed_valid", vd, 0);
        end else if (sb.size() == 0) begin
          chk("sb_empty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("latency", c, e.lat);
          if (e.is_d) chk("d_rdata_o", d_rdata_o, e.ed);
          else chk("if_rdata_o", {32'h0, if_rdata_o}, e.ed);
        end
        break;
      end
      if (!t.ev && c == t.lat) break;
    end
    if (t.ev) chk("valid_seen", got, 1);
    tick();
    drop_all();
  endtask

  vec_t tv[9];
  bit   exp_seq[10];

  initial begin
    int dv_c;
    int iv_c;
    int n;
    vec_t rv_after;

    tv[0] = mk(1, 0, 64'h100, 64'h0, 8'hFF, 0, 0,
               64'hDEADBEEF_CAFEF00D, -1, 1,
               64'hDEADBEEF_CAFEF00D, 3);
    tv[1] = mk(1, 1, 64'h108, 64'h11223344_55667788,
               8'h0F, 1, 2, 64'h0, -1, 1, 64'h0, 6);
    tv[2] = mk(0, 0, 64'h204, 64'h0, 8'h0, 3, 0,
               64'h01234567_89ABCDEF, -1, 1,
               64'h01234567, 6);
    tv[3] = mk(0, 0, 64'h200, 64'h0, 8'h0, 0, 1,
               64'h01234567_89ABCDEF, -1, 1,
               64'h89ABCDEF, 4);
    tv[4] = mk(0, 0, 64'h300, 64'h0, 8'h0, 0, 1,
               64'hFFFF0000_FFFF0000, 2, 0, 64'h0, 4);
    tv[5] = mk(1, 0, 64'h400, 64'h0, 8'hFF, 0, 0,
               64'hA5A5A5A5_5A5A5A5A, -1, 1,
               64'hA5A5A5A5_5A5A5A5A, 3);
    tv[6] = mk(1, 0, 64'h408, 64'h0, 8'h3C, 1, 0,
               64'h0F0F0F0F_F0F0F0F0, 1, 1,
               64'h0F0F0F0F_F0F0F0F0, 4);
    tv[7] = mk(0, 0, 64'h310, 64'h0, 8'h0, 1, 0,
               64'h77777777_88888888, 1, 0, 64'h0, 4);
    tv[8] = mk(0, 0, 64'h30C, 64'h0, 8'h0, 0, 0,
               64'hCAFEBABE_12345678, -1, 1,
               64'hCAFEBABE, 3);
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    // Reset state
    rstn = 0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_m_req_o", m_req_o, 0);
    chk("rst_m_addr_o", m_addr_o, 0);
    chk("rst_d_valid_o", d_valid_o, 0);
    chk("rst_if_valid_o", if_valid_o, 0);
    chk("rst_d_rdata_o", d_rdata_o, 0);
    chk("rst_if_rdata_o", {32'h0, if_rdata_o}, 0);
    tick();
    rstn = 1;
    tick();

    foreach (tv[i]) run_vec(tv[i]);

    // Simultaneous requests: D first, then I in the next IDLE
    rdy_lat = 0; rv_lat = 0;
    rsp_data = 64'h11112222_33334444;
    dv_c = -1; iv_c = -1;
    tick();
    d_req_i = 1; d_addr_i = 64'h600; d_be_i = 8'hFF;
    if_req_i = 1; if_addr_i = 64'h500;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) tick();
      if (dv_c >= 0 && c == dv_c + 1) d_req_i = 0;
      if (iv_c >= 0 && c == iv_c + 1) if_req_i = 0;
      @(negedge clk);
      if (c == 1) chk("both_first_addr", m_addr_o, 64'h600);
      if (d_valid_o && dv_c < 0) begin
        dv_c = c;
        chk("both_d_rdata", d_rdata_o, 64'h11112222_33334444);
      end
      if (if_valid_o && iv_c < 0) begin
        iv_c = c;
        chk("both_if_rdata", {32'h0, if_rdata_o}, 64'h33334444);
      end
    end
    chk("both_d_cycle", dv_c, 3);
    chk("both_if_cycle", iv_c, 7);
    drop_all();
    tick();

    // Starvation: continuous D traffic with fetch held
    rsp_data = 64'h55556666_77778888;
    n = 0;
    tick();
    d_req_i = 1; d_addr_i = 64'h800; d_be_i = 8'hFF;
    if_req_i = 1; if_addr_i = 64'h900;
    for (int c = 0; c < 80 && n < 10; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (d_valid_o || if_valid_o) begin
        chk($sformatf("starve_grant_%0d", n), d_valid_o, exp_seq[n]);
        n++;
      end
    end
    chk("starve_done", n, 10);
    tick();
    drop_all();
    tick();

    // Reset while in WAIT, then a late memory response
    rdy_lat = 0; rv_lat = 3;
    rsp_data = 64'h99999999_99999999;
    tick();
    d_req_i = 1; d_addr_i = 64'h700; d_be_i = 8'hFF;
    tick();
    tick();
    tick();
    rstn = 0;
    drop_all();
    tick();
    rstn = 1;
    @(negedge clk);
    chk("wrst_m_req_o", m_req_o, 0);
    chk("wrst_m_we_o", m_we_o, 0);
    chk("wrst_m_addr_o", m_addr_o, 0);
    chk("wrst_m_wdata_o", m_wdata_o, 0);
    chk("wrst_m_be_o", m_be_o, 0);
    chk("wrst_d_rdata_o", d_rdata_o, 0);
    chk("wrst_if_rdata_o", {32'h0, if_rdata_o}, 0);
    chk("wrst_valids", {d_valid_o, if_valid_o}, 0);
    chk("wrst_stalls", {d_stall_o, if_stall_o}, 0);
    for (int c = 5; c < 9; c++) begin
      tick();
      @(negedge clk);
      chk("late_rvalid_valid", {d_valid_o, if_valid_o}, 0);
      chk("late_rvalid_rdata", d_rdata_o, 0);
      chk("late_rvalid_m_req", m_req_o, 0);
    end

    rv_after = mk(1, 0, 64'hA00, 64'h0, 8'hFF, 0, 0,
                  64'h13572468_ACE0BDF1, -1, 1,
                  64'h13572468_ACE0BDF1, 3);
    run_vec(rv_after);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
